// File: rtl/sram_sp_1rw_pkg.sv
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared memory-subsystem constants and types. Holds the geometry
//             of the two supported foundry macros (ibm130 RA1SHD 4096x8 and
//             sky130 2 KB x32) and address/data typedefs sized from the
//             technology selected at build time (MEM_TECH_SKY130 define).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  // ibm130 RA1SHD: 4096 words x 8 bits
  localparam int MEM_ADDR_W_IBM = 12;
  localparam int MEM_DATA_W_IBM = 8;

  // sky130 2 KB macro: 10-bit address field, only 9 bits decoded (512 x 32)
  localparam int MEM_ADDR_W_SKY      = 10;
  localparam int MEM_ADDR_W_SKY_USED = 9;
  localparam int MEM_DATA_W_SKY      = 32;

`ifdef MEM_TECH_SKY130
  localparam int MEM_ADDR_W = MEM_ADDR_W_SKY;
  localparam int MEM_DATA_W = MEM_DATA_W_SKY;
`else
  localparam int MEM_ADDR_W = MEM_ADDR_W_IBM;
  localparam int MEM_DATA_W = MEM_DATA_W_IBM;
`endif

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_t;

  // Word count of a fully decoded array of the given address width.
  function automatic int mem_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_sp_1rw_if.sv
// ============================================================================
//  Module   : sram_sp_1rw_if
//  Purpose  : Access bus of the single-port 1RW SRAM model.
//  Signals  : CEN  chip enable, active low (1 = idle)
//             WEN  write enable, active low (0 = write, 1 = read)
//             A    word address (ADDR_W bits)
//             D    write data   (DATA_W bits)
//             Q    registered read data (DATA_W bits), driven by the memory
//  Modports : master - requester (drives CEN/WEN/A/D, observes Q)
//             slave  - memory    (observes CEN/WEN/A/D, drives Q)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_sp_1rw_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W_IBM,
  parameter int DATA_W = MEM_DATA_W_IBM
) ();

  logic              CEN;
  logic              WEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;

  modport master (
    output CEN,
    output WEN,
    output A,
    output D,
    input  Q
  );

  modport slave (
    input  CEN,
    input  WEN,
    input  A,
    input  D,
    output Q
  );

endinterface

`default_nettype wire

// File: rtl/sram_sp_1rw_wrappers.sv
// ============================================================================
//  Module   : sram_sp_1rw_ra1shd / sram_sp_1rw_sky130
//  Purpose  : Thin port-mapping wrappers presenting the foundry macro
//             footprints on top of sram_sp_1rw. Compiled only by integration
//             flows that define MEM_TECH_WRAPPERS.
//  Ports    : RA1SHD : CLK, rst_n, CEN, WEN, A[11:0], D[7:0], Q[7:0]
//             sky130 : clk0, rst_n, csb0, web0, addr0[8:0], din0[31:0],
//                      dout0[31:0]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MEM_TECH_WRAPPERS

module sram_sp_1rw_ra1shd
  import mem_pkg::*;
(
  input  wire                      CLK,
  input  wire                      rst_n,
  input  wire                      CEN,
  input  wire                      WEN,
  input  wire [MEM_ADDR_W_IBM-1:0] A,
  input  wire [MEM_DATA_W_IBM-1:0] D,
  output logic [MEM_DATA_W_IBM-1:0] Q
);

  sram_sp_1rw_if #(.ADDR_W(MEM_ADDR_W_IBM), .DATA_W(MEM_DATA_W_IBM)) w_bus ();

  assign w_bus.CEN = CEN;
  assign w_bus.WEN = WEN;
  assign w_bus.A   = A;
  assign w_bus.D   = D;
  assign Q         = w_bus.Q;

  sram_sp_1rw #(
    .ADDR_W (MEM_ADDR_W_IBM),
    .DATA_W (MEM_DATA_W_IBM)
  ) u_ram (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (w_bus)
  );

endmodule

module sram_sp_1rw_sky130
  import mem_pkg::*;
(
  input  wire                           clk0,
  input  wire                           rst_n,
  input  wire                           csb0,
  input  wire                           web0,
  input  wire [MEM_ADDR_W_SKY_USED-1:0] addr0,
  input  wire [MEM_DATA_W_SKY-1:0]      din0,
  output logic [MEM_DATA_W_SKY-1:0]     dout0
);

  sram_sp_1rw_if #(.ADDR_W(MEM_ADDR_W_SKY_USED), .DATA_W(MEM_DATA_W_SKY)) w_bus ();

  // csb0/web0 already have the model's active-low sense: no inversion.
  // The macro's byte mask is tied all-ones, i.e. every write is a full word,
  // which is exactly what the model implements.
  assign w_bus.CEN = csb0;
  assign w_bus.WEN = web0;
  assign w_bus.A   = addr0;
  assign w_bus.D   = din0;
  assign dout0     = w_bus.Q;

  sram_sp_1rw #(
    .ADDR_W (MEM_ADDR_W_SKY_USED),
    .DATA_W (MEM_DATA_W_SKY)
  ) u_ram (
    .CLK   (clk0),
    .rst_n (rst_n),
    .bus   (w_bus)
  );

endmodule

`endif

`default_nettype wire

// File: rtl/sram_sp_1rw.sv
// ============================================================================
//  Module   : sram_sp_1rw
//  Purpose  : Technology-neutral synchronous single-port 1RW SRAM model.
//             One access per rising CLK edge (read or write), registered read
//             data with one cycle of latency, no write-through. The storage
//             array 'mem' is never reset so benches may preload it through
//             hierarchy and its contents survive rst_n.
//  Ports    : CLK    clock, all accesses on the rising edge
//             rst_n  asynchronous active-low reset, clears Q only
//             bus    sram_sp_1rw_if.slave (CEN, WEN, A, D in; Q out)
//  Params   : ADDR_W address width, DATA_W word width,
//             DEPTH  word count, must equal 2**ADDR_W
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_sp_1rw
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W_IBM,
  parameter int DATA_W = MEM_DATA_W_IBM,
  parameter int DEPTH  = mem_depth(ADDR_W)
) (
  input  wire          CLK,
  input  wire          rst_n,
  sram_sp_1rw_if.slave bus
);

  // Fully decoded: every address value maps to a word, so no bounds check.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic              w_ctrl_x;

  // Unknown control is flagged only in simulation; synthesis sees a constant.
`ifndef SYNTHESIS
  assign w_ctrl_x = $isunknown({bus.CEN, bus.WEN});
`else
  assign w_ctrl_x = 1'b0;
`endif

  // Array and output register share one process so that an edge seen while
  // rst_n is low takes the reset branch and the write is suppressed, without
  // sampling rst_n as ordinary data elsewhere. The array itself is never
  // cleared by the reset branch.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (w_ctrl_x) begin
      r_q <= 'x;
      // Selected but with an unknown write enable: the word is corrupted.
      if (bus.CEN === 1'b0) begin
        mem[bus.A] <= 'x;
      end
    end else if (!bus.CEN) begin
      if (!bus.WEN) begin
        mem[bus.A] <= bus.D;   // Q deliberately holds on a write
      end else begin
        r_q <= mem[bus.A];
      end
    end
  end

  assign bus.Q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_sp_1rw.sv
// ============================================================================
//  Module   : tb_sram_sp_1rw
//  Purpose  : Directed self-checking bench for sram_sp_1rw (4096 x 8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_sp_1rw;

  logic CLK;
  logic rst_n;
  int   checks;
  int   failures;

  sram_sp_1rw_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  sram_sp_1rw #(
    .ADDR_W (12),
    .DATA_W (8),
    .DEPTH  (4096)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one access at the falling edge, then return 1 ns after the
  // rising edge that samples it.
  task automatic cycle(input logic cen, input logic wen,
                       input logic [11:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus.CEN = cen;
    bus.WEN = wen;
    bus.A   = a;
    bus.D   = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    bus.CEN = 1'b1;
    bus.WEN = 1'b1;
    bus.A   = '0;
    bus.D   = '0;
    for (int i = 0; i < 4096; i++) dut.mem[i] = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (bus.Q !== 8'h00) begin
      failures++;
      $display("FAIL reset_q got=%h exp=%h", bus.Q, 8'h00);
    end
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b0, 12'(i), 8'(i));
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b1, 12'(i), 8'hFF);
      checks++;
      if (bus.Q !== 8'(i)) begin
        failures++;
        $display("FAIL fill_read a=%0d got=%h exp=%h", i, bus.Q, 8'(i));
      end
    end
  endtask

  task automatic test_idle_hold;
    cycle(1'b0, 1'b1, 12'd5, 8'h00);
    checks++;
    if (bus.Q !== 8'h05) begin
      failures++;
      $display("FAIL idle_pre got=%h exp=%h", bus.Q, 8'h05);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, k[0], 12'd7, 8'hEE);
      checks++;
      if (bus.Q !== 8'h05) begin
        failures++;
        $display("FAIL idle_hold k=%0d got=%h exp=%h", k, bus.Q, 8'h05);
      end
    end
    cycle(1'b0, 1'b1, 12'd7, 8'h00);
    checks++;
    if (bus.Q !== 8'h07) begin
      failures++;
      $display("FAIL idle_mem7 got=%h exp=%h", bus.Q, 8'h07);
    end
  endtask

  task automatic test_write_no_disturb;
    cycle(1'b0, 1'b1, 12'd3, 8'h00);
    checks++;
    if (bus.Q !== 8'h03) begin
      failures++;
      $display("FAIL wnd_pre got=%h exp=%h", bus.Q, 8'h03);
    end
    cycle(1'b0, 1'b0, 12'd3, 8'hAA);
    checks++;
    if (bus.Q !== 8'h03) begin
      failures++;
      $display("FAIL wnd_hold got=%h exp=%h", bus.Q, 8'h03);
    end
    cycle(1'b0, 1'b1, 12'd3, 8'h00);
    checks++;
    if (bus.Q !== 8'hAA) begin
      failures++;
      $display("FAIL wnd_new got=%h exp=%h", bus.Q, 8'hAA);
    end
  endtask

  task automatic test_boundary;
    cycle(1'b0, 1'b0, 12'd4095, 8'hA5);
    cycle(1'b0, 1'b0, 12'd0,    8'h5A);
    cycle(1'b0, 1'b1, 12'd4095, 8'h00);
    checks++;
    if (bus.Q !== 8'hA5) begin
      failures++;
      $display("FAIL bound_top got=%h exp=%h", bus.Q, 8'hA5);
    end
    cycle(1'b0, 1'b1, 12'd0, 8'h00);
    checks++;
    if (bus.Q !== 8'h5A) begin
      failures++;
      $display("FAIL bound_zero got=%h exp=%h", bus.Q, 8'h5A);
    end
  endtask

  task automatic test_back_to_back;
    cycle(1'b0, 1'b0, 12'd20, 8'h33);
    cycle(1'b0, 1'b1, 12'd20, 8'h00);
    checks++;
    if (bus.Q !== 8'h33) begin
      failures++;
      $display("FAIL b2b_raw got=%h exp=%h", bus.Q, 8'h33);
    end
    cycle(1'b0, 1'b0, 12'd21, 8'h44);
    cycle(1'b0, 1'b1, 12'd20, 8'h00);
    checks++;
    if (bus.Q !== 8'h33) begin
      failures++;
      $display("FAIL b2b_other got=%h exp=%h", bus.Q, 8'h33);
    end
    cycle(1'b0, 1'b1, 12'd21, 8'h00);
    checks++;
    if (bus.Q !== 8'h44) begin
      failures++;
      $display("FAIL b2b_second got=%h exp=%h", bus.Q, 8'h44);
    end
  endtask

  task automatic test_async_reset;
    cycle(1'b0, 1'b1, 12'd31, 8'h00);
    checks++;
    if (bus.Q !== 8'h1F) begin
      failures++;
      $display("FAIL ar_pre got=%h exp=%h", bus.Q, 8'h1F);
    end
    bus.CEN = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.Q !== 8'h00) begin
      failures++;
      $display("FAIL ar_immediate got=%h exp=%h", bus.Q, 8'h00);
    end
    @(negedge CLK);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 12'd31, 8'h00);
    checks++;
    if (bus.Q !== 8'h1F) begin
      failures++;
      $display("FAIL ar_retained got=%h exp=%h", bus.Q, 8'h1F);
    end
  endtask

  task automatic test_reset_coincident;
    @(negedge CLK);
    bus.CEN = 1'b0;
    bus.WEN = 1'b0;
    bus.A   = 12'd10;
    bus.D   = 8'h77;
    #4;
    rst_n = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (bus.Q !== 8'h00) begin
      failures++;
      $display("FAIL rc_q got=%h exp=%h", bus.Q, 8'h00);
    end
    @(negedge CLK);
    bus.CEN = 1'b1;
    rst_n   = 1'b1;
    cycle(1'b0, 1'b1, 12'd10, 8'h00);
    checks++;
    if (bus.Q !== 8'h0A) begin
      failures++;
      $display("FAIL rc_mem10 got=%h exp=%h", bus.Q, 8'h0A);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_idle_hold();
    test_write_no_disturb();
    test_boundary();
    test_back_to_back();
    test_async_reset();
    test_reset_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
